// File: rtl/int_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_ctrl_if -- cpu <-> interrupt controller bus
//
// Groups the two-register configuration port and the interrupt handshake.
//   cfg_we    : register write strobe                (cpu -> ctrl)
//   cfg_addr  : 0 = MASK, 1 = STATUS                 (cpu -> ctrl)
//   cfg_wdata : write data                           (cpu -> ctrl)
//   cfg_rdata : combinational read data for cfg_addr (ctrl -> cpu)
//   int_req   : registered interrupt request         (ctrl -> cpu)
//   int_vec   : requesting source, valid with req    (ctrl -> cpu)
//   int_ack   : one-cycle accept pulse               (cpu -> ctrl)
//   int_eoi   : one-cycle end-of-interrupt pulse     (cpu -> ctrl)
// Modports: master = cpu side, slave = controller side.
// -----------------------------------------------------------------------------
interface int_ctrl_if #(
  parameter int VEC_W = 2
);
  logic             cfg_we;
  logic             cfg_addr;
  logic [7:0]       cfg_wdata;
  logic [7:0]       cfg_rdata;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic             int_ack;
  logic             int_eoi;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, int_ack, int_eoi,
    input  cfg_rdata, int_req, int_vec
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, int_ack, int_eoi,
    output cfg_rdata, int_req, int_vec
  );
endinterface

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- interrupt controller for up to four peripheral sources
//
// Latches rising edges of irq into pending bits, masks them, arbitrates one
// winner and sequences it through a request / ack / end-of-interrupt
// handshake with the cpu.
//
// Ports:
//   clk   : system clock, all state on rising edge
//   reset : asynchronous, active-low reset
//   irq   : [NSRC-1:0] level interrupt lines (synchronous to clk)
//   bus   : int_ctrl_if.slave -- config registers + interrupt handshake
//
// Registers (cfg_addr):
//   0 MASK   : rw, bits [NSRC-1:0] enable sources, upper bits read 0
//   1 STATUS : read {in_service[3:0], pending[3:0]}; write 1 to clear pending
//
// Parameters: NSRC (1..4, source 0 highest fixed priority),
//             VEC_W (2**VEC_W >= NSRC).
//
// Build option: define INTC_ROTATE_EN for rotating priority (search starts at
// a pointer that moves past each acknowledged source). Undefined = fixed
// priority, lowest index wins, no pointer register.
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter int NSRC  = 4,
  parameter int VEC_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  int_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [NSRC-1:0]   irq_d;
  logic [NSRC-1:0]   pending, pending_nxt;
  logic [NSRC-1:0]   mask, mask_nxt;
  logic [NSRC-1:0]   in_service;
  logic              req_q, req_nxt;
  logic [VEC_W-1:0]  vec_q, vec_nxt;

  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   w1c_clr;
  logic [NSRC-1:0]   ack_clr;
  logic [NSRC-1:0]   survive;
  logic [NSRC-1:0]   eligible;
  logic [NSRC-1:0]   vec_onehot;
  logic [VEC_W-1:0]  win;
  logic              ack_take;
  logic              eoi_take;
  logic              still_valid;

  // Lowest set bit index; zero when the vector is empty.
  function automatic logic [VEC_W-1:0] lowest(input logic [NSRC-1:0] v);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) r = VEC_W'(i);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Event capture and register-port decode
  // ---------------------------------------------------------------------------
  assign rise     = irq & ~irq_d;
  assign mask_nxt = (bus.cfg_we && !bus.cfg_addr) ? bus.cfg_wdata[NSRC-1:0] : mask;
  assign w1c_clr  = (bus.cfg_we &&  bus.cfg_addr) ? bus.cfg_wdata[NSRC-1:0] : '0;

  always_comb begin
    vec_onehot = '0;
    for (int i = 0; i < NSRC; i++) begin
      vec_onehot[i] = (vec_q == VEC_W'(i));
    end
  end

  assign ack_take = (state == REQ)     && bus.int_ack;
  assign eoi_take = (state == SERVICE) && bus.int_eoi;
  assign ack_clr  = ack_take ? vec_onehot : '0;

  // A rise in the same cycle as any clear wins, so it is OR-ed in last.
  assign pending_nxt = (pending & ~(w1c_clr | ack_clr)) | rise;

  // What remains requestable after this cycle's clears, ignoring ack (ack has
  // priority over withdrawal and is decided separately).
  assign survive     = (pending & ~w1c_clr) | rise;
  assign still_valid = |(vec_onehot & survive & mask_nxt);

  // Candidates must still be enabled and uncleared after this cycle, so a
  // same-cycle W1C or mask write never produces a one-cycle stray request.
  // A rise this cycle is not yet a candidate: pending is registered first.
  assign eligible = pending & mask & ~w1c_clr & mask_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef INTC_ROTATE_EN
  localparam int SW = VEC_W + 1;

  logic [VEC_W-1:0]  ptr;
  logic [2*NSRC-1:0] dbl;
  logic [NSRC-1:0]   rot;
  logic [SW-1:0]     sum;

  always_comb begin
    // Rotate so the pointer's source lands at bit 0, pick the lowest, then
    // map the rotated index back with a modulo-NSRC add.
    dbl = {eligible, eligible} >> ptr;
    rot = dbl[NSRC-1:0];
    sum = {1'b0, ptr} + {1'b0, lowest(rot)};
    if (sum >= SW'(NSRC)) sum = sum - SW'(NSRC);
    win = sum[VEC_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (ack_take) begin
      ptr <= (vec_q == VEC_W'(NSRC - 1)) ? '0 : vec_q + 1'b1;
    end
  end
`else
  assign win = lowest(eligible);
`endif

  // ---------------------------------------------------------------------------
  // Handshake FSM -- next state and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every variable of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned infers a latch.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    vec_nxt   = vec_q;
    unique case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          vec_nxt   = win;
        end
      end
      REQ: begin
        // Vector is frozen here: no re-arbitration until the request ends.
        if (bus.int_ack) begin
          state_nxt = SERVICE;
          req_nxt   = 1'b0;
        end else if (!still_valid) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      SERVICE: begin
        req_nxt = 1'b0;
        if (bus.int_eoi) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      req_q <= 1'b0;
      vec_q <= '0;
    end else begin
      state <= state_nxt;
      req_q <= req_nxt;
      vec_q <= vec_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Source state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_d      <= '0;
      pending    <= '0;
      mask       <= '0;
      in_service <= '0;
    end else begin
      irq_d   <= irq;
      pending <= pending_nxt;
      mask    <= mask_nxt;
      if (eoi_take) begin
        in_service <= '0;
      end else if (ack_take) begin
        in_service <= in_service | vec_onehot;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.int_req   = req_q;
  assign bus.int_vec   = vec_q;
  assign bus.cfg_rdata = bus.cfg_addr ? {4'(in_service), 4'(pending)} : 8'(mask);

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl -- directed self-checking bench for int_ctrl (NSRC=4, VEC_W=2).
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq   = 4'h0;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef INTC_ROTATE_EN
  localparam logic [1:0] FIRST_VEC   = 2'd3;
  localparam logic [1:0] SECOND_VEC  = 2'd0;
  localparam logic [7:0] PRIO_STATUS = 8'h81;
`else
  localparam logic [1:0] FIRST_VEC   = 2'd0;
  localparam logic [1:0] SECOND_VEC  = 2'd3;
  localparam logic [7:0] PRIO_STATUS = 8'h18;
`endif

  int_ctrl_if #(.VEC_W(2)) bus ();

  int_ctrl #(.NSRC(4), .VEC_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .irq   (irq),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    bus.cfg_we    = 1'b1;
    tick();
    bus.cfg_we    = 1'b0;
    bus.cfg_wdata = 8'h00;
  endtask

  task automatic rd(input logic a, output logic [7:0] d);
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_rdata;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq = v;
    tick();
    irq = 4'h0;
  endtask

  task automatic ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic eoi();
    bus.int_eoi = 1'b1;
    tick();
    bus.int_eoi = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] d;
    #1 reset = 1'b0;
    #1;
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", d); end
    rd(1'b0, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h want 00", d); end
    n_tests++;
    if (bus.int_req !== 1'b0 || bus.int_vec !== 2'd0) begin
      n_fail++; $display("FAIL reset_req: got req=%b vec=%0d want req=0 vec=0", bus.int_req, bus.int_vec);
    end
    #8 reset = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_basic();
    logic [7:0] d;
    wr(1'b0, 8'h0F);
    pulse_irq(4'b0100);
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h04 || bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL basic_pending: got status=%h req=%b want 04 req=0", d, bus.int_req);
    end
    tick();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_vec !== 2'd2) begin
      n_fail++; $display("FAIL basic_req: got req=%b vec=%0d want req=1 vec=2", bus.int_req, bus.int_vec);
    end
    ack();
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h40 || bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL basic_ack: got status=%h req=%b want 40 req=0", d, bus.int_req);
    end
    tick();
    eoi();
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL basic_eoi: got status=%h want 00", d); end
    tick();
    n_tests++;
    if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got req=%b want 0", bus.int_req); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_priority();
    logic [7:0] d;
    // Source 0 alone first; under rotation this leaves the pointer at 1.
    pulse_irq(4'b0001);
    tick();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_vec !== 2'd0) begin
      n_fail++; $display("FAIL prio_single: got req=%b vec=%0d want req=1 vec=0", bus.int_req, bus.int_vec);
    end
    ack();
    eoi();
    pulse_irq(4'b1001);
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h09) begin n_fail++; $display("FAIL prio_pending: got status=%h want 09", d); end
    tick();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_vec !== FIRST_VEC) begin
      n_fail++; $display("FAIL prio_first: got req=%b vec=%0d want req=1 vec=%0d", bus.int_req, bus.int_vec, FIRST_VEC);
    end
    ack();
    rd(1'b1, d);
    n_tests++;
    if (d !== PRIO_STATUS) begin n_fail++; $display("FAIL prio_service: got status=%h want %h", d, PRIO_STATUS); end
    eoi();
    n_tests++;
    if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL prio_gap: got req=%b want 0", bus.int_req); end
    tick();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_vec !== SECOND_VEC) begin
      n_fail++; $display("FAIL prio_second: got req=%b vec=%0d want req=1 vec=%0d", bus.int_req, bus.int_vec, SECOND_VEC);
    end
    ack();
    eoi();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mask_w1c();
    logic [7:0] d;
    wr(1'b0, 8'h00);
    pulse_irq(4'b0010);
    tick();
    tick();
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h02 || bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL mask_hold: got status=%h req=%b want 02 req=0", d, bus.int_req);
    end
    wr(1'b0, 8'h02);
    rd(1'b0, d);
    n_tests++;
    if (d !== 8'h02 || bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL mask_write: got mask=%h req=%b want 02 req=0", d, bus.int_req);
    end
    tick();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_vec !== 2'd1) begin
      n_fail++; $display("FAIL mask_unmask_req: got req=%b vec=%0d want req=1 vec=1", bus.int_req, bus.int_vec);
    end
    // eoi outside SERVICE is ignored.
    eoi();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_vec !== 2'd1) begin
      n_fail++; $display("FAIL spurious_eoi: got req=%b vec=%0d want req=1 vec=1", bus.int_req, bus.int_vec);
    end
    // W1C withdraws the request without an ack.
    wr(1'b1, 8'h02);
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h00 || bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL w1c_withdraw: got status=%h req=%b want 00 req=0", d, bus.int_req);
    end
    // ack while IDLE is ignored.
    ack();
    tick();
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h00 || bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL spurious_ack: got status=%h req=%b want 00 req=0", d, bus.int_req);
    end
    // W1C in the same cycle as a new rise: the set wins.
    pulse_irq(4'b0010);
    tick();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_vec !== 2'd1) begin
      n_fail++; $display("FAIL w1c_rearm: got req=%b vec=%0d want req=1 vec=1", bus.int_req, bus.int_vec);
    end
    irq = 4'b0010;
    wr(1'b1, 8'h02);
    irq = 4'h0;
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h02 || bus.int_req !== 1'b1) begin
      n_fail++; $display("FAIL w1c_set_wins: got status=%h req=%b want 02 req=1", d, bus.int_req);
    end
    ack();
    eoi();
    wr(1'b0, 8'h0F);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_service_reentry();
    logic [7:0] d;
    pulse_irq(4'b0001);
    tick();
    ack();
    pulse_irq(4'b0001);
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h11 || bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL reentry_pending: got status=%h req=%b want 11 req=0", d, bus.int_req);
    end
    tick();
    tick();
    n_tests++;
    if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL reentry_no_nest: got req=%b want 0", bus.int_req); end
    eoi();
    n_tests++;
    if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL reentry_eoi_edge: got req=%b want 0", bus.int_req); end
    tick();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_vec !== 2'd0) begin
      n_fail++; $display("FAIL reentry_rereq: got req=%b vec=%0d want req=1 vec=0", bus.int_req, bus.int_vec);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [7:0] d;
    irq = 4'b0001;
    tick();
    tick();
    n_tests++;
    if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL rst_setup_req: got req=%b want 1", bus.int_req); end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (bus.int_req !== 1'b0 || bus.int_vec !== 2'd0) begin
      n_fail++; $display("FAIL rst_async_req: got req=%b vec=%0d want req=0 vec=0", bus.int_req, bus.int_vec);
    end
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL rst_async_status: got %h want 00", d); end
    rd(1'b0, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL rst_async_mask: got %h want 00", d); end
    tick();
    #3 reset = 1'b1;
    tick();
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h01 || bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_held_irq: got status=%h req=%b want 01 req=0", d, bus.int_req);
    end
    irq = 4'h0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 1'b0;
    bus.cfg_wdata = 8'h00;
    bus.int_ack   = 1'b0;
    bus.int_eoi   = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_mask_w1c();
    test_service_reentry();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
